// File: rtl/dma_pkg.sv
// ============================================================================
// Module  : dma_pkg
// Brief   : Register offsets, CTRL/STAT bit positions and FSM states for dma_copy.
// Revision: 1.0
// ============================================================================
`default_nettype none

package dma_pkg;

    // Word offsets, compared against addr[3:2]
    localparam logic [1:0] c_reg_src  = 2'd0;
    localparam logic [1:0] c_reg_dst  = 2'd1;
    localparam logic [1:0] c_reg_len  = 2'd2;
    localparam logic [1:0] c_reg_ctrl = 2'd3;

    localparam int c_ctrl_start_bit = 0;
    localparam int c_stat_busy_bit  = 0;
    localparam int c_stat_done_bit  = 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DONE_CHK = 2'd1,
        ST_READ     = 2'd2,
        ST_WRITE    = 2'd3
    } dma_state_t;

endpackage

`default_nettype wire

// File: rtl/dma_copy.sv
// ============================================================================
// Module  : dma_copy
// Brief   : Register-programmed word copy engine with a single bus master port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dma_copy
    import dma_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dma_sel,
    input  logic [3:0]  addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] dma_data_i,
    output logic [31:0] dma_data_o,
    output logic        dma_ready,
    output logic        m_valid,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic        m_ready,
    input  logic [31:0] m_rdata
);

    logic [31:0]      r_src;
    logic [31:0]      r_dst;
    logic [LEN_W-1:0] r_len;
    logic [31:0]      r_wsrc;
    logic [31:0]      r_wdst;
    logic [LEN_W-1:0] r_wcnt;
    logic [31:0]      r_buf;
    logic             r_done;
    dma_state_t       r_state;

    logic        w_busy;
    logic        w_acc;
    logic        w_cfg_wr;
    logic        w_start;
    logic [31:0] w_rdata;

    assign w_busy   = (r_state != ST_IDLE);
    // One access per select: the ready pulse itself blocks a second sample
    assign w_acc    = dma_sel & ~dma_ready;
    assign w_cfg_wr = w_acc & (|wstrb) & ~w_busy;
    assign w_start  = w_cfg_wr & (addr[3:2] == c_reg_ctrl) & dma_data_i[c_ctrl_start_bit];

    always_comb begin
        w_rdata = 32'd0;
        case (addr[3:2])
            c_reg_src:  w_rdata = r_src;
            c_reg_dst:  w_rdata = r_dst;
            c_reg_len:  w_rdata = 32'(r_len);
            c_reg_ctrl: begin
                w_rdata[c_stat_busy_bit] = w_busy;
                w_rdata[c_stat_done_bit] = r_done;
            end
            default:    w_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dma_ready  <= 1'b0;
            dma_data_o <= 32'd0;
            r_src      <= 32'd0;
            r_dst      <= 32'd0;
            r_len      <= '0;
        end else begin
            dma_ready <= w_acc;
            if (w_acc) begin
                dma_data_o <= w_rdata;
            end
            if (w_cfg_wr) begin
                case (addr[3:2])
                    c_reg_src: r_src <= {dma_data_i[31:2], 2'b00};
                    c_reg_dst: r_dst <= {dma_data_i[31:2], 2'b00};
                    c_reg_len: r_len <= dma_data_i[LEN_W-1:0];
                    default:   ;
                endcase
            end
        end
    end

    // Each bus phase raises m_valid one cycle after entering its state, which
    // guarantees an idle cycle between consecutive master transactions.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_wsrc  <= 32'd0;
            r_wdst  <= 32'd0;
            r_wcnt  <= '0;
            r_buf   <= 32'd0;
            r_done  <= 1'b0;
            m_valid <= 1'b0;
            m_addr  <= 32'd0;
            m_wdata <= 32'd0;
            m_wstrb <= 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    m_valid <= 1'b0;
                    if (w_start) begin
                        r_wsrc  <= r_src;
                        r_wdst  <= r_dst;
                        r_wcnt  <= r_len;
                        r_done  <= 1'b0;
                        r_state <= ST_DONE_CHK;
                    end
                end
                ST_DONE_CHK: begin
                    if (r_wcnt == '0) begin
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (!m_valid) begin
                        m_valid <= 1'b1;
                        m_addr  <= r_wsrc;
                        m_wstrb <= 4'h0;
                    end else if (m_ready) begin
                        r_buf   <= m_rdata;
                        m_valid <= 1'b0;
                        r_state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (!m_valid) begin
                        m_valid <= 1'b1;
                        m_addr  <= r_wdst;
                        m_wdata <= r_buf;
                        m_wstrb <= 4'hF;
                    end else if (m_ready) begin
                        m_valid <= 1'b0;
                        r_wsrc  <= r_wsrc + 32'd4;
                        r_wdst  <= r_wdst + 32'd4;
                        r_wcnt  <= r_wcnt - LEN_W'(1);
                        r_state <= ST_DONE_CHK;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dma_copy.sv
// ============================================================================
// Module  : tb_dma_copy
// Brief   : Scoreboard bench for dma_copy with a random-latency memory slave.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dma_copy;

    localparam int LEN_W = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        dma_sel;
    logic [3:0]  addr;
    logic [3:0]  wstrb;
    logic [31:0] dma_data_i;
    logic [31:0] dma_data_o;
    logic        dma_ready;
    logic        m_valid;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_ready;
    logic [31:0] m_rdata;

    dma_copy #(.LEN_W(LEN_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .dma_sel    (dma_sel),
        .addr       (addr),
        .wstrb      (wstrb),
        .dma_data_i (dma_data_i),
        .dma_data_o (dma_data_o),
        .dma_ready  (dma_ready),
        .m_valid    (m_valid),
        .m_addr     (m_addr),
        .m_wdata    (m_wdata),
        .m_wstrb    (m_wstrb),
        .m_ready    (m_ready),
        .m_rdata    (m_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } txn_t;

    txn_t        exp_q[$];
    logic [31:0] mem [logic [31:0]];
    int          total = 0;
    int          bad = 0;
    int          n_txn = 0;
    int          n_wr = 0;
    int          max_lat = 0;

    int          s_wait = -1;
    bit          s_acked = 1'b0;
    txn_t        s_hold;

    // Memory slave and monitor: checks each offered transaction against the queue head
    always @(negedge clk) begin
        if (reset) begin
            m_ready = 1'b0;
            s_wait  = -1;
            s_acked = 1'b0;
        end else if (s_acked) begin
            m_ready = 1'b0;
            s_acked = 1'b0;
            total++;
            if (m_valid !== 1'b0) begin
                bad++;
                $display("FAIL valid_drop: m_valid=%b required 0", m_valid);
            end
        end else if (m_valid === 1'b1) begin
            if (s_wait < 0) begin
                s_hold = '{addr: m_addr, data: m_wdata, strb: m_wstrb};
                s_wait = int'($urandom_range(max_lat, 0));
            end else begin
                total++;
                if (m_addr !== s_hold.addr || m_wdata !== s_hold.data || m_wstrb !== s_hold.strb) begin
                    bad++;
                    $display("FAIL stable: addr=%h data=%h strb=%h required addr=%h data=%h strb=%h",
                             m_addr, m_wdata, m_wstrb, s_hold.addr, s_hold.data, s_hold.strb);
                end
            end
            if (s_wait == 0) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_txn: addr=%h strb=%h required no transaction", m_addr, m_wstrb);
                end else begin
                    txn_t e;
                    e = exp_q.pop_front();
                    if (m_addr !== e.addr || m_wstrb !== e.strb ||
                        (e.strb != 4'h0 && m_wdata !== e.data)) begin
                        bad++;
                        $display("FAIL txn: addr=%h data=%h strb=%h required addr=%h data=%h strb=%h",
                                 m_addr, m_wdata, m_wstrb, e.addr, e.data, e.strb);
                    end
                end
                if (m_wstrb == 4'h0) begin
                    m_rdata = mem.exists(m_addr) ? mem[m_addr] : 32'hDEAD_BEEF;
                end else begin
                    mem[m_addr] = m_wdata;
                    n_wr++;
                end
                n_txn++;
                m_ready = 1'b1;
                s_acked = 1'b1;
                s_wait  = -1;
            end else begin
                s_wait--;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic reg_acc(input logic [3:0] a, input logic [3:0] s, input logic [31:0] d,
                           output logic [31:0] q);
        @(negedge clk);
        dma_sel    = 1'b1;
        addr       = a;
        wstrb      = s;
        dma_data_i = d;
        @(negedge clk);
        check("dma_ready", {31'd0, dma_ready}, 32'd1);
        q       = dma_data_o;
        dma_sel = 1'b0;
        wstrb   = 4'h0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        logic [31:0] q;
        reg_acc(a, 4'hF, d, q);
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] q);
        reg_acc(a, 4'h0, 32'd0, q);
    endtask

    // Reference model: a copy of len words is len (read src+4i, write dst+4i) pairs
    task automatic start_copy(input logic [31:0] src, input logic [31:0] dst, input int len);
        wr(4'h0, src);
        wr(4'h4, dst);
        wr(4'h8, 32'(len));
        for (int i = 0; i < len; i++) begin
            logic [31:0] sa, da, v;
            sa = src + 32'(4 * i);
            da = dst + 32'(4 * i);
            v  = $urandom;
            mem[sa] = v;
            exp_q.push_back('{addr: sa, data: 32'd0, strb: 4'h0});
            exp_q.push_back('{addr: da, data: v, strb: 4'hF});
        end
        wr(4'hC, 32'd1);
    endtask

    task automatic finish_copy(input string name, input int base, input int len);
        logic [31:0] q;
        bit          ok;
        ok = 1'b0;
        q  = 32'd0;
        for (int k = 0; k < 3000; k++) begin
            rd(4'hC, q);
            if (q[0] == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: status=%h required busy=0", name, q);
        end
        check({name, "_status"}, q, 32'h2);
        check({name, "_queue"}, 32'(exp_q.size()), 32'd0);
        check({name, "_count"}, 32'(n_txn - base), 32'(2 * len));
    endtask

    initial begin
        logic [31:0] q;
        int          base;
        int          target;
        logic [31:0] src;
        logic [31:0] dst;
        int          len;

        reset      = 1'b1;
        dma_sel    = 1'b0;
        addr       = 4'h0;
        wstrb      = 4'h0;
        dma_data_i = 32'd0;
        m_ready    = 1'b0;
        m_rdata    = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_master", {m_valid, m_wstrb, 27'd0}, 32'd0);
        check("reset_maddr", m_addr, 32'd0);
        check("reset_mwdata", m_wdata, 32'd0);
        check("reset_regport", {dma_ready, 31'd0} | dma_data_o, 32'd0);
        reset = 1'b0;

        for (int r = 0; r < 4; r++) begin
            rd(4'(r * 4), q);
            check("reset_reg", q, 32'd0);
        end

        // Basic copy with zero-wait memory, plus alignment masking
        max_lat = 0;
        wr(4'h0, 32'h0000_0103);
        rd(4'h0, q);
        check("src_align", q, 32'h0000_0100);
        base = n_txn;
        start_copy(32'h100, 32'h200, 4);
        finish_copy("basic", base, 4);

        // Zero length: done without any bus traffic
        base = n_txn;
        start_copy(32'h100, 32'h200, 0);
        rd(4'hC, q);
        check("zero_status", q, 32'h2);
        check("zero_count", 32'(n_txn - base), 32'd0);

        // Random copies with random slave latency
        max_lat = 5;
        for (int t = 0; t < 4; t++) begin
            src  = 32'h1000_0000 | ($urandom & 32'h00FF_FFFC);
            dst  = 32'h2000_0000 | ($urandom & 32'h00FF_FFFC);
            len  = int'($urandom_range(6, 1));
            base = n_txn;
            start_copy(src, dst, len);
            finish_copy("random", base, len);
        end

        // Register and start writes while busy must be ignored
        max_lat = 2;
        base = n_txn;
        start_copy(32'h3000, 32'h4000, 8);
        wr(4'h8, 32'd1);
        wr(4'hC, 32'd1);
        wr(4'h0, 32'h5550);
        finish_copy("busy", base, 8);
        rd(4'h8, q);
        check("busy_len", q, 32'd8);
        rd(4'h0, q);
        check("busy_src", q, 32'h3000);

        // Source address wraps through zero
        max_lat = 0;
        base = n_txn;
        start_copy(32'hFFFF_FFFC, 32'h300, 2);
        finish_copy("wrap", base, 2);

        // Reset after the second write of a transfer completes
        max_lat = 1;
        start_copy(32'h400, 32'h800, 6);
        target = n_wr + 2;
        for (int k = 0; k < 500 && n_wr < target; k++) @(posedge clk);
        check("reset_wait", 32'(n_wr >= target), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("reset_abort_valid", {31'd0, m_valid}, 32'd0);
        @(negedge clk);
        check("reset_abort_port", {dma_ready, 31'd0} | dma_data_o, 32'd0);
        reset = 1'b0;
        for (int r = 0; r < 4; r++) begin
            rd(4'(r * 4), q);
            check("abort_reg", q, 32'd0);
        end

        max_lat = 3;
        base = n_txn;
        start_copy(32'h600, 32'hA00, 3);
        finish_copy("after_reset", base, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
